// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int TO_W        = 16;
    localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after last, with wrap.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    // Scan from last+1 around to last; the first hit wins.
    always_comb begin
        int   idx_s;
        logic hit_s;
        logic found_s;
        win_idx = '0;
        found_s = 1'b0;
        idx_s   = 0;
        hit_s   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_s   = (int'(last) + i) % NREQ;
            hit_s   = !found_s && req[idx_s];
            win_idx = hit_s ? IDX_W'(idx_s) : win_idx;
            found_s = found_s || hit_s;
        end
        win          = '0;
        win[win_idx] = found_s;
        any          = found_s;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller port between NREQ requesters,
// driving the level-sensitive sel/ready handshake with a per-access timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   mc_sel,
    output logic                   mc_we,
    output logic [ADDR_W-1:0]      mc_addr,
    output logic [DATA_W-1:0]      mc_wdata,
    input  logic                   mc_ready,
    input  logic [DATA_W-1:0]      mc_rdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_r;
    arb_state_t       state_s;
    logic [IDX_W-1:0] last_r;
    logic [TO_W-1:0]  cnt_r;
    logic [NREQ-1:0]  win_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             any_s;
    logic             grant_s;
    logic             timeout_s;
    logic             finish_s;
    logic             abort_s;
    logic [NREQ-1:0]  gnt_s;
    logic [NREQ-1:0]  done_s;
    logic             err_s;
    logic             sel_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .last    (last_r),
        .win     (win_s),
        .win_idx (win_idx_s),
        .any     (any_s)
    );

    assign grant_s   = (state_r == IDLE) && any_s && mc_ready;
    assign timeout_s = ((state_r == ISSUE) || (state_r == WAIT)) && (cnt_r == TO_W'(TIMEOUT - 1));
    // A response landing on the last allowed cycle still completes normally.
    assign finish_s  = (state_r == WAIT) && mc_ready;
    assign abort_s   = timeout_s && !finish_s;

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = grant_s ? ISSUE : IDLE;
            ISSUE:   state_s = abort_s ? DONE : (mc_ready ? ISSUE : WAIT);
            WAIT:    state_s = (finish_s || abort_s) ? DONE : WAIT;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        gnt_s  = gnt;
        done_s = '0;
        err_s  = 1'b0;
        sel_s  = 1'b0;
        case (state_r)
            IDLE: begin
                gnt_s = grant_s ? win_s : '0;
                sel_s = grant_s;
            end
            ISSUE: begin
                sel_s  = mc_ready && !abort_s;
                done_s = abort_s ? gnt : '0;
                err_s  = abort_s;
            end
            WAIT: begin
                done_s = (finish_s || abort_s) ? gnt : '0;
                err_s  = abort_s;
            end
            DONE:    gnt_s = '0;
            default: gnt_s = '0;
        endcase
    end

    // Output registers, controller command, round-robin pointer and timeout counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            mc_sel    <= 1'b0;
            mc_we     <= 1'b0;
            mc_addr   <= '0;
            mc_wdata  <= '0;
            rsp_rdata <= '0;
            last_r    <= IDX_W'(NREQ - 1);
            cnt_r     <= '0;
        end else begin
            gnt    <= gnt_s;
            done   <= done_s;
            err    <= err_s;
            mc_sel <= sel_s;
            if (grant_s) begin
                mc_we    <= req_we[win_idx_s];
                mc_addr  <= req_addr[int'(win_idx_s) * ADDR_W +: ADDR_W];
                mc_wdata <= req_wdata[int'(win_idx_s) * DATA_W +: DATA_W];
                last_r   <= win_idx_s;
                cnt_r    <= '0;
            end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
                cnt_r <= cnt_r + TO_W'(1);
            end
            if (abort_s) begin
                rsp_rdata <= '0;
            end else if (finish_s && !mc_we) begin
                rsp_rdata <= mc_rdata;
            end
        end
    end

endmodule
